// File: rtl/reg_pipe.sv
// reg_pipe: elastic register pipeline of DEPTH stages, WIDTH bits wide.
//
// Each stage holds a data word and a valid bit. A stage advances when it is
// empty or when the stage after it advances, so empty stages (bubbles) are
// filled even while the output is stalled.
//
// Optional feature: define REG_PIPE_COUNT_EN to add the registered occupancy
// output `count`. When undefined, the port and its logic do not exist.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   en               global enable; low freezes every stage
//   flush            synchronous clear of all valid bits (priority over en)
//   in_valid/in_data/in_ready     upstream handshake
//   out_valid/out_data/out_ready  downstream handshake (outputs registered)
//   count            occupancy 0..DEPTH (REG_PIPE_COUNT_EN only)
module reg_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef REG_PIPE_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Advance chain runs from the output end backwards. A local carry keeps the
  // ripple inside one variable instead of feeding the adv vector back on itself.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = en & ~flush & (~v_q[DEPTH-1] | out_ready);
    adv[DEPTH-1] = carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry  = en & ~flush & (~v_q[i] | carry);
      adv[i] = carry;
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = in_valid;
        if (in_valid) data_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          // Data only moves with a valid word; a bubble leaves old data in place.
          if (v_q[i-1]) data_d[i] = data_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  // rst_n gates in_ready so nothing is offered as accepted while held in reset.
  assign in_ready  = adv[0] & rst_n;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic          xfer_in;
  logic          xfer_out;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    xfer_in  = in_valid & in_ready;
    xfer_out = out_valid & out_ready & en & ~flush;
    count_d  = count_q;
    if (flush) begin
      count_d = '0;
    end else if (xfer_in && !xfer_out) begin
      count_d = count_q + CW'(1);
    end else if (!xfer_in && xfer_out) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
module tb_reg_pipe;
  localparam int               WIDTH = 8;
  localparam int               DEPTH = 4;
  localparam logic [WIDTH-1:0] RVAL  = 8'h5A;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
`ifdef REG_PIPE_COUNT_EN
  logic [2:0]       count;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef REG_PIPE_COUNT_EN
    , .count(count)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: transfers are judged at the falling edge, halfway between
  // the rising edges where they take effect.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
`ifdef REG_PIPE_COUNT_EN
      checks++;
      if (count !== 3'(exp_q.size())) begin
        errors++;
        $display("FAIL count got %0d want %0d", count, exp_q.size());
      end
`endif
      if (out_valid && out_ready && en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got %h want none", out_data);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL sb_order got %h want %h", out_data, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (exp_q.size() == 0 && !out_valid) break;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got left=%0d out_valid=%b want 0 0", name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    en = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out_data !== RVAL) begin errors++; $display("FAIL rst_out_data got %h want %h", out_data, RVAL); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int j = 0; j < 22; j++) begin
      step();
      in_valid = (j < 16);
      in_data  = 8'(j + 1);
      #1;
      if (j < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready cyc %0d got %b want 1", j, in_ready); end
      end
      checks++;
      if (out_valid !== (j >= 4 && j < 20)) begin
        errors++;
        $display("FAIL stream_valid cyc %0d got %b want %b", j, out_valid, (j >= 4 && j < 20));
      end
      if (j >= 4 && j < 20) begin
        checks++;
        if (out_data !== 8'(j - 3)) begin errors++; $display("FAIL stream_data cyc %0d got %h want %h", j, out_data, 8'(j - 3)); end
      end
    end
    drain("stream");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int j = 0; j < 9; j++) begin
      step();
      if (j < 5)      begin in_valid = 1'b1; in_data = 8'hA0 + 8'(j); end
      else if (j < 7) begin in_valid = 1'b1; in_data = 8'hA4; end
      else if (j == 7) begin in_valid = 1'b1; in_data = 8'hA5; end
      else            in_valid = 1'b0;
      if (j >= 6) out_ready = 1'b1;
      #1;
      if (j < 8) begin
        checks++;
        if (in_ready !== (j < 4 || j >= 6)) begin
          errors++;
          $display("FAIL bp_ready cyc %0d got %b want %b", j, in_ready, (j < 4 || j >= 6));
        end
      end
      if (j == 5) begin
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid got %b want 1", out_valid); end
        if (out_data !== 8'hA0) begin errors++; $display("FAIL bp_head got %h want a0", out_data); end
      end
    end
    drain("bp");
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    for (int j = 0; j < 9; j++) begin
      step();
      in_valid = (j == 0 || j == 3);
      in_data  = (j == 0) ? 8'h11 : 8'h22;
      if (j >= 6) out_ready = 1'b1;
      #1;
      if (j == 3 || j == 5) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_ready cyc %0d got %b want 1", j, in_ready); end
      end
      if (j >= 6) begin
        checks++;
        if (out_valid !== (j < 8)) begin errors++; $display("FAIL bub_valid cyc %0d got %b want %b", j, out_valid, (j < 8)); end
      end
      if (j == 6 || j == 7) begin
        checks++;
        if (out_data !== ((j == 6) ? 8'h11 : 8'h22)) begin
          errors++;
          $display("FAIL bub_data cyc %0d got %h want %h", j, out_data, (j == 6) ? 8'h11 : 8'h22);
        end
      end
    end
    drain("bub");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      in_valid = 1'b1;
      in_data  = 8'h31 + 8'(j);
    end
    step();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got %h want none", out_data); end
    end
  endtask

  task automatic test_enable();
    int idx = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      en       = !(c >= 6 && c < 9);
      in_valid = (idx < 12);
      in_data  = 8'h61 + 8'(idx);
      #1;
      if (!en) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL en_ready cyc %0d got %b want 0", c, in_ready); end
      end
      if (c >= 7 && c <= 9) begin
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL en_hold_valid cyc %0d got %b want 1", c, out_valid); end
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL en_hold_data cyc %0d got %h want %h", c, out_data, (exp_q.size() == 0) ? 8'h00 : exp_q[0]);
        end
      end
      if (in_valid && in_ready) idx++;
      if (idx == 12 && c > 10) break;
    end
    en = 1'b1;
    drain("en");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(j);
    end
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    if (out_data !== RVAL) begin errors++; $display("FAIL rmid_data got %h want %h", out_data, RVAL); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b want 0", in_ready); end
`ifdef REG_PIPE_COUNT_EN
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
`endif
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_first_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    drain("rmid");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
